// File: rtl/assoc_data_cache_if.sv
// CPU load/store port, flush request and block-wide memory port of the set-associative cache.
// read/write are held until busywait is low; a memory transfer completes at the posedge where mem_busywait is low while mem_read or mem_write is high.
interface assoc_data_cache_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int BLOCK_BYTES = 4
) ();
  localparam int OFF_W   = $clog2(BLOCK_BYTES);
  localparam int MADDR_W = ADDR_WIDTH - OFF_W;
  localparam int LINE_W  = 8 * BLOCK_BYTES;

  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0]            writedata;
  logic [7:0]            readdata;
  logic                  busywait;
  logic                  flush;
  logic                  flush_done;
  logic                  mem_read;
  logic                  mem_write;
  logic [MADDR_W-1:0]    mem_address;
  logic [LINE_W-1:0]     mem_writedata;
  logic [LINE_W-1:0]     mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  read, write, address, writedata, flush, mem_readdata, mem_busywait,
    output readdata, busywait, flush_done, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, flush, mem_readdata, mem_busywait,
    input  readdata, busywait, flush_done, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/assoc_data_cache.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement
// and a whole-cache flush that writes back every dirty line.
module assoc_data_cache #(
  parameter int ADDR_WIDTH  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int NUM_SETS    = 4,
  parameter int WAYS        = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  assoc_data_cache_if.slave    bus,
  output logic [2:0]           state_dbg
);
  localparam int OFF_W   = $clog2(BLOCK_BYTES);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int LINE_W  = 8 * BLOCK_BYTES;
  localparam int WAY_W   = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE, WRITEBACK, FETCH, UPDATE, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t            state_q;
  logic              valid_q [NUM_SETS][WAYS];
  logic              dirty_q [NUM_SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][WAYS];
  logic [LINE_W-1:0] data_q  [NUM_SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [NUM_SETS][WAYS];
  logic [IDX_W-1:0]  op_set;
  logic [WAY_W-1:0]  op_way;
  logic [LINE_W-1:0] fill_q;
  logic              done_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic [OFF_W-1:0]  off;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              has_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  old_way;
  logic [WAY_W-1:0]  victim;
  logic              req;
  logic              last_line;
  logic              touch_en;
  logic [IDX_W-1:0]  touch_set;
  logic [WAY_W-1:0]  touch_way;
  logic [WAY_W-1:0]  touch_age;

  assign idx    = bus.address[OFF_W +: IDX_W];
  assign tag_in = bus.address[ADDR_WIDTH-1 -: TAG_W];
  assign off    = bus.address[OFF_W-1:0];
  assign req    = bus.read | bus.write;

  // Way-parallel lookup plus victim choice: lowest invalid way, else the oldest.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) old_way = WAY_W'(w);
    end
    victim = has_inv ? inv_way : old_way;
  end

  assign bus.readdata   = data_q[idx][hit_way][{off, 3'b000} +: 8];
  assign bus.busywait   = !reset && req && !(state_q == IDLE && hit);
  assign bus.flush_done = done_q;
  assign state_dbg      = state_q;

  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    case (state_q)
      WRITEBACK, FLUSH_WB: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {tag_q[op_set][op_way], op_set};
        bus.mem_writedata = data_q[op_set][op_way];
      end
      FETCH: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {tag_in, idx};
      end
      default: ;
    endcase
  end

  assign last_line = (op_set == IDX_W'(NUM_SETS - 1)) && (op_way == WAY_W'(WAYS - 1));
  assign touch_en  = (state_q == IDLE && req && hit) || (state_q == UPDATE);
  assign touch_set = (state_q == UPDATE) ? op_set : idx;
  assign touch_way = (state_q == UPDATE) ? op_way : hit_way;
  assign touch_age = age_q[touch_set][touch_way];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_set  <= '0;
      op_way  <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (bus.write) begin
                data_q[idx][hit_way][{off, 3'b000} +: 8] <= bus.writedata;
                dirty_q[idx][hit_way] <= 1'b1;
              end
            end else begin
              op_set  <= idx;
              op_way  <= victim;
              state_q <= dirty_q[idx][victim] ? WRITEBACK : FETCH;
            end
          end else if (bus.flush && !done_q) begin
            // done_q guard stops a still-held flush from restarting in the done cycle
            op_set  <= '0;
            op_way  <= '0;
            state_q <= FLUSH_SCAN;
          end
        end
        WRITEBACK: if (!bus.mem_busywait) state_q <= FETCH;
        FETCH: begin
          if (!bus.mem_busywait) begin
            fill_q  <= bus.mem_readdata;
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          data_q[op_set][op_way]  <= fill_q;
          tag_q[op_set][op_way]   <= tag_in;
          valid_q[op_set][op_way] <= 1'b1;
          dirty_q[op_set][op_way] <= 1'b0;
          state_q                 <= IDLE;
        end
        FLUSH_SCAN, FLUSH_WB: begin
          if (state_q == FLUSH_SCAN && valid_q[op_set][op_way] && dirty_q[op_set][op_way]) begin
            state_q <= FLUSH_WB;
          end else if (state_q == FLUSH_SCAN || !bus.mem_busywait) begin
            if (state_q == FLUSH_WB) dirty_q[op_set][op_way] <= 1'b0;
            if (last_line) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= FLUSH_SCAN;
              if (op_way == WAY_W'(WAYS - 1)) begin
                op_way <= '0;
                op_set <= op_set + IDX_W'(1);
              end else begin
                op_way <= op_way + WAY_W'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (touch_en) begin
        for (int v = 0; v < WAYS; v++) begin
          if (WAY_W'(v) == touch_way) age_q[touch_set][v] <= '0;
          else if (age_q[touch_set][v] < touch_age) age_q[touch_set][v] <= age_q[touch_set][v] + WAY_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache: a latency-programmable block memory model,
// a write-back scoreboard and hand-computed expectations for hits, misses, LRU, flush and reset.
module tb_assoc_data_cache;
  localparam int ADDR_WIDTH  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int NUM_SETS    = 4;
  localparam int WAYS        = 2;
  localparam int MADDR_W     = 6;
  localparam int LINE_W      = 32;
  localparam int W           = MADDR_W + LINE_W;
  localparam int BOUND       = 200;

  logic       clock;
  logic       reset;
  logic [2:0] state_dbg;

  assoc_data_cache_if #(.ADDR_WIDTH(ADDR_WIDTH), .BLOCK_BYTES(BLOCK_BYTES)) bus ();

  assoc_data_cache #(
    .ADDR_WIDTH(ADDR_WIDTH), .BLOCK_BYTES(BLOCK_BYTES), .NUM_SETS(NUM_SETS), .WAYS(WAYS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [LINE_W-1:0] mem_arr [64];
  int                lat;
  int                busy_cnt;
  int                rd_cnt;
  int                done_cnt;
  logic [MADDR_W-1:0] last_rd_addr;
  logic [W-1:0]      obs_q [$];
  logic [W-1:0]      exp_q [$];

  assign bus.mem_readdata = mem_arr[bus.mem_address];

  always @(negedge clock) begin
    if (bus.mem_read || bus.mem_write) begin
      if (busy_cnt < lat) begin
        bus.mem_busywait = 1'b1;
        busy_cnt++;
      end else begin
        bus.mem_busywait = 1'b0;
        busy_cnt = 0;
      end
    end else begin
      bus.mem_busywait = 1'b0;
      busy_cnt = 0;
    end
  end

  always @(posedge clock) begin
    if (bus.mem_read && !bus.mem_busywait) begin
      rd_cnt++;
      last_rd_addr = bus.mem_address;
    end
    if (bus.mem_write && !bus.mem_busywait) begin
      obs_q.push_back({bus.mem_address, bus.mem_writedata});
      mem_arr[bus.mem_address] = bus.mem_writedata;
    end
    if (bus.flush_done) done_cnt++;
  end

  // ---------------- checking ----------------
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    check({tag, " wb count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() != 0 && exp_q.size() != 0)
      check({tag, " wb block"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rdata, output int stall);
    @(negedge clock);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    stall = 0;
    #1;
    while (bus.busywait && stall < BOUND) begin
      @(negedge clock);
      #1;
      stall++;
    end
    rdata = bus.readdata;
    @(posedge clock);
    #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic do_flush(output int cyc);
    @(negedge clock);
    bus.flush = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.flush_done && cyc < BOUND);
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    @(negedge clock);
    check("flush_done one cycle", 64'(bus.flush_done), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rdata;
  int         stall;
  int         cyc;
  int         rd0;
  int         dn0;

  initial begin
    n_vec = 0; n_err = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; lat = 3;
    last_rd_addr = '0;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'hA5A50000 | 32'(i);
    mem_arr[6'h05] = 32'hDDCCBBAA;
    mem_arr[6'h15] = 32'h13121110;
    mem_arr[6'h25] = 32'h23222120;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0; bus.flush = 1'b0;
    reset = 1'b1;

    // outputs under reset, even with a request pending
    repeat (2) @(negedge clock);
    bus.read = 1'b1; bus.address = 8'h14;
    #1;
    check("rst busywait", 64'(bus.busywait), 64'd0);
    check("rst flush_done", 64'(bus.flush_done), 64'd0);
    check("rst mem_read", 64'(bus.mem_read), 64'd0);
    check("rst mem_write", 64'(bus.mem_write), 64'd0);
    check("rst mem_address", 64'(bus.mem_address), 64'd0);
    check("rst mem_writedata", 64'(bus.mem_writedata), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // cold read: clean miss costs fetch (3 busy + 1) + 2
    rd0 = rd_cnt;
    cpu_op(1'b1, 1'b0, 8'h14, 8'h00, rdata, stall);
    check("cold rd data", 64'(rdata), 64'hAA);
    check("cold rd stall", 64'(stall), 64'd6);
    check("cold rd fetches", 64'(rd_cnt - rd0), 64'd1);
    check("cold rd maddr", 64'(last_rd_addr), 64'h05);
    check_wb("cold rd");

    rd0 = rd_cnt;
    cpu_op(1'b1, 1'b0, 8'h15, 8'h00, rdata, stall);
    check("hit rd data", 64'(rdata), 64'hBB);
    check("hit rd stall", 64'(stall), 64'd0);
    check("hit rd fetches", 64'(rd_cnt - rd0), 64'd0);

    // cold write allocates into way1
    rd0 = rd_cnt;
    cpu_op(1'b0, 1'b1, 8'h54, 8'h5A, rdata, stall);
    check("cold wr stall", 64'(stall), 64'd6);
    check("cold wr fetches", 64'(rd_cnt - rd0), 64'd1);
    check("cold wr maddr", 64'(last_rd_addr), 64'h15);
    check_wb("cold wr");

    // touch way0, then a conflicting miss evicts dirty way1
    cpu_op(1'b1, 1'b0, 8'h14, 8'h00, rdata, stall);
    check("touch way0 stall", 64'(stall), 64'd0);
    exp_q.push_back({6'h15, 32'h1312115A});
    rd0 = rd_cnt;
    cpu_op(1'b1, 1'b0, 8'h94, 8'h00, rdata, stall);
    check("dirty miss data", 64'(rdata), 64'h20);
    check("dirty miss stall", 64'(stall), 64'd10);
    check("dirty miss fetches", 64'(rd_cnt - rd0), 64'd1);
    check("dirty miss maddr", 64'(last_rd_addr), 64'h25);
    check_wb("dirty miss");
    cpu_op(1'b1, 1'b0, 8'h14, 8'h00, rdata, stall);
    check("way0 kept data", 64'(rdata), 64'hAA);
    check("way0 kept stall", 64'(stall), 64'd0);

    // read+write together: write wins, old byte still visible that cycle
    cpu_op(1'b1, 1'b1, 8'h15, 8'h77, rdata, stall);
    check("rw stall", 64'(stall), 64'd0);
    check("rw readdata", 64'(rdata), 64'hBB);
    cpu_op(1'b1, 1'b0, 8'h15, 8'h00, rdata, stall);
    check("rw readback", 64'(rdata), 64'h77);
    check_wb("rw");

    // flush with one dirty line at (set1, way0)
    exp_q.push_back({6'h05, 32'hDDCC77AA});
    dn0 = done_cnt;
    do_flush(cyc);
    check("flush1 cycles", 64'(cyc), 64'd13);
    check("flush1 pulses", 64'(done_cnt - dn0), 64'd1);
    check_wb("flush1");
    cpu_op(1'b1, 1'b0, 8'h15, 8'h00, rdata, stall);
    check("post flush data", 64'(rdata), 64'h77);
    check("post flush stall", 64'(stall), 64'd0);

    // all-clean flush: NUM_SETS*WAYS scan cycles then the done cycle
    dn0 = done_cnt;
    do_flush(cyc);
    check("flush2 cycles", 64'(cyc), 64'(NUM_SETS * WAYS + 1));
    check("flush2 pulses", 64'(done_cnt - dn0), 64'd1);
    check_wb("flush2");

    // reset in the middle of a long fetch
    lat = 20;
    rd0 = rd_cnt;
    @(negedge clock);
    bus.read = 1'b1; bus.address = 8'h24;
    repeat (3) @(negedge clock);
    #1;
    check("mid fetch state", 64'(state_dbg), 64'd2);
    check("mid fetch mem_read", 64'(bus.mem_read), 64'd1);
    check("mid fetch maddr", 64'(bus.mem_address), 64'h09);
    #1;
    reset = 1'b1;
    #1;
    check("rst drop mem_read", 64'(bus.mem_read), 64'd0);
    check("rst drop state", 64'(state_dbg), 64'd0);
    check("rst drop busywait", 64'(bus.busywait), 64'd0);
    @(negedge clock);
    reset = 1'b0; bus.read = 1'b0; lat = 3;
    cpu_op(1'b1, 1'b0, 8'h14, 8'h00, rdata, stall);
    check("after rst fetches", 64'(rd_cnt - rd0), 64'd1);
    check("after rst stall", 64'(stall), 64'd6);
    check("after rst data", 64'(rdata), 64'hAA);
    check_wb("after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/assoc_data_cache.md
Name: assoc_data_cache

Overview:
- Parametrised, N-way set-associative, write-back, write-allocate data cache between the CPU load/store port and block-wide data memory.
- Successor to the direct-mapped 8-line cache. Generalises address width, block size, set count and associativity.
- Adds LRU replacement and a whole-cache flush (write back all dirty lines) with a completion pulse.

Parameters:
- ADDR_WIDTH, 8, CPU byte-address width.
- BLOCK_BYTES, 4, bytes per line; power of 2, >=2. Memory word width = 8*BLOCK_BYTES.
- NUM_SETS, 4, number of sets; power of 2, >=2.
- WAYS, 2, ways per set; power of 2, 2..8.
- Derived: OFF_W=clog2(BLOCK_BYTES), IDX_W=clog2(NUM_SETS), TAG_W=ADDR_WIDTH-IDX_W-OFF_W, MADDR_W=ADDR_WIDTH-OFF_W.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  CPU load request; held until busywait low.
- write  in  1  CPU store request; held until busywait low.
- address  in  ADDR_WIDTH  byte address; {tag,index,offset}.
- writedata  in  8  store byte.
- readdata  out  8  load byte; combinational from the hitting way.
- busywait  out  1  CPU stall.
- flush  in  1  level request: write back all dirty lines; held until flush_done.
- flush_done  out  1  one-cycle pulse when the flush completes.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_address  out  MADDR_W  block address {tag,index}.
- mem_writedata  out  8*BLOCK_BYTES  victim block.
- mem_readdata  in  8*BLOCK_BYTES  fetched block.
- mem_busywait  in  1  memory busy; a transfer completes at the posedge where it is sampled low while a request is high.

Behaviour:
- Reset (async): all lines valid=0, dirty=0, tag=0, data=0; LRU age of way w = w; state IDLE.
  - Outputs while reset is high: busywait=0, flush_done=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
- Hit: in IDLE, a valid way whose tag matches. Way-parallel lookup.
  - busywait = (read|write) & !(state==IDLE & hit), combinational, so a hit costs zero stall cycles.
  - Hit read: readdata = byte[offset] of the hit way, same cycle.
  - Hit write: at posedge, store byte[offset] and set dirty.
  - Any hit updates LRU at posedge: hit way age=0; ways with age < old age increment.
- Both read and write high: write wins. readdata is still driven.
- Miss in IDLE: choose the victim at the entry posedge and latch it.
  - Victim = lowest-numbered invalid way; else the way with age WAYS-1.
  - Victim dirty -> WRITEBACK; otherwise -> FETCH.
- WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim data. When mem_busywait is sampled low -> FETCH.
- FETCH: mem_read=1, mem_address={addr tag,index}. When mem_busywait is sampled low, capture mem_readdata -> UPDATE.
- UPDATE: write the block, tag, valid=1, dirty=0 into the victim way; set the LRU touch -> IDLE. The retried access then hits, and a write completes on that hit.
- Miss penalty:
  - Clean miss: fetch cycles + 2.
  - Dirty miss: adds write-back cycles.
- mem_read/mem_write/mem_address/mem_writedata are combinational from state. They are 0 in IDLE/UPDATE/FLUSH_SCAN. Never both high.
- Flush:
  - Accepted in IDLE only when read=write=0; CPU requests take priority. Scan pointer (set,way) resets to (0,0).
  - FLUSH_SCAN: one line per cycle. A dirty valid line -> FLUSH_WB, which writes it back (as WRITEBACK) then clears dirty, keeping valid. Otherwise advance.
  - After line (NUM_SETS-1, WAYS-1): flush_done=1 for one cycle, return to IDLE.
  - All-clean cache: exactly NUM_SETS*WAYS scan cycles, then done.
  - busywait=1 for any read/write during a flush.
- Reset mid-transfer: state returns to IDLE immediately and mem requests drop without a clock edge. The partial transfer is abandoned and all lines are invalid.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE, FLUSH_SCAN, FLUSH_WB.

Test Plan:
Defaults apply: tag=addr[7:4], index=addr[3:2], offset=addr[1:0].
- Cold read 0x14; memory returns 0xDDCCBBAA after 3 busy cycles -> mem_read=1, mem_address=0x05, no mem_write; busywait falls after UPDATE with readdata=0xAA. Next-cycle read 0x15 -> readdata=0xBB with busywait=0 in the same cycle, no mem_read.
- Write 0x54 data 0x5A (cold) -> fetch of mem_address 0x15 into way1 (way0 holds tag 1); busywait drops on the hit cycle; line dirty; no mem_write.
- Read 0x14 (touch way0), then read 0x94 -> victim is way1 (tag 5, dirty): mem_write with mem_address=0x15 and mem_writedata[7:0]=0x5A, then mem_read with mem_address=0x25. A later read 0x14 still hits.
- Flush with exactly one dirty line -> exactly one mem_write, flush_done pulses once. A second flush issues no mem_write and completes after 8 scan cycles.
- Assert reset during FETCH with mem_busywait=1 -> mem_read=0 immediately. After release, read 0x14 misses (mem_read=1).
- Read and write both high at hit address 0x15, writedata 0x77 -> byte is written and dirty is set. A subsequent read 0x15 returns 0x77.
